// File: rtl/video_rastercmd_pkg.sv
// ---------------------------------------------------------------------------
// video_rastercmd_pkg
// Shared definitions for the raster command sequencer:
//   - command word field positions
//   - opcode values
//   - FSM state encoding
//   - control-bit indices (the same order the video block expects)
// ---------------------------------------------------------------------------
package video_rastercmd_pkg;

  localparam int CMD_W    = 32;

  // Command word fields
  localparam int LINE_MSB = 31;
  localparam int LINE_LSB = 23;
  localparam int OP_MSB   = 22;
  localparam int OP_LSB   = 19;
  localparam int VAL_MSB  = 8;
  localparam int VAL_LSB  = 0;

  localparam int LINE_W   = LINE_MSB - LINE_LSB + 1;
  localparam int OP_W     = OP_MSB - OP_LSB + 1;
  localparam int VAL_W    = VAL_MSB - VAL_LSB + 1;

  // The sequencer read port only returns {line, opcode, value}; bits
  // [18:9] are reserved and only visible through the CPU port.
  localparam int SEQ_W    = LINE_W + OP_W + VAL_W;

  // Opcodes (6..15 behave as NOP)
  localparam logic [OP_W-1:0] OP_END     = 4'd0;
  localparam logic [OP_W-1:0] OP_NOP     = 4'd1;
  localparam logic [OP_W-1:0] OP_SETX    = 4'd2;
  localparam logic [OP_W-1:0] OP_SETY    = 4'd3;
  localparam logic [OP_W-1:0] OP_SETCTRL = 4'd4;
  localparam logic [OP_W-1:0] OP_IRQ     = 4'd5;

  // Control bit indices
  localparam int CTRL_TEXT_EN   = 0;
  localparam int CTRL_TEXT_80   = 1;
  localparam int CTRL_TEXT_PRI  = 2;
  localparam int CTRL_GFX_EN    = 3;
  localparam int CTRL_GFX_TILE  = 4;
  localparam int CTRL_SPR_EN    = 5;
  localparam int CTRL_W         = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Map the low bits of a SETCTRL value onto the named control bits.
  function automatic logic [CTRL_W-1:0] ctrl_from_value(input logic [CTRL_W-1:0] v);
    logic [CTRL_W-1:0] c;
    c                = '0;
    c[CTRL_TEXT_EN]  = v[CTRL_TEXT_EN];
    c[CTRL_TEXT_80]  = v[CTRL_TEXT_80];
    c[CTRL_TEXT_PRI] = v[CTRL_TEXT_PRI];
    c[CTRL_GFX_EN]   = v[CTRL_GFX_EN];
    c[CTRL_GFX_TILE] = v[CTRL_GFX_TILE];
    c[CTRL_SPR_EN]   = v[CTRL_SPR_EN];
    return c;
  endfunction

endpackage

// File: rtl/video_rastercmd_ram.sv
// ---------------------------------------------------------------------------
// rastercmd_ram
// Dual-port DEPTH x 32 command RAM, both ports on clk, 1-cycle read latency.
//   Port A (CPU):       i_a_addr, i_a_wdata, i_a_wren, o_a_rdata (32 bits)
//   Port B (sequencer): i_b_addr, i_b_rden, o_b_cmd = {line, opcode, value}
// Reads are read-first: a read at the address being written on the same
// edge returns the previous contents.
// ---------------------------------------------------------------------------
module rastercmd_ram
  import video_rastercmd_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    i_a_addr,
  input  logic [CMD_W-1:0] i_a_wdata,
  input  logic             i_a_wren,
  output logic [CMD_W-1:0] o_a_rdata,
  input  logic [AW-1:0]    i_b_addr,
  input  logic             i_b_rden,
  output logic [SEQ_W-1:0] o_b_cmd
);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [CMD_W-1:0] r_a_rdata;
  logic [SEQ_W-1:0] r_b_cmd;

  always_ff @(posedge clk) begin
    if (i_a_wren) begin
      r_mem[i_a_addr] <= i_a_wdata;
    end
    r_a_rdata <= r_mem[i_a_addr];
    // Port B holds its last word while not reading, so the command stays
    // stable for as long as the sequencer sits in DECODE/WAIT.
    if (i_b_rden) begin
      r_b_cmd <= {r_mem[i_b_addr][LINE_MSB:OP_LSB], r_mem[i_b_addr][VAL_MSB:VAL_LSB]};
    end
  end

  assign o_a_rdata = r_a_rdata;
  assign o_b_cmd   = r_b_cmd;

endmodule

// File: rtl/video_rastercmd.sv
// ---------------------------------------------------------------------------
// video_rastercmd
// Per-scanline register sequencer in front of the video block. Each frame it
// walks a CPU-written command list and updates the scroll/control registers
// when the current scanline reaches each command's target line.
//
// Ports:
//   clk, reset (async, active-low)
//   enable                 - sequencer enable, sampled on newframe
//   base_scroll_x/y, base_ctrl - register values loaded at frame start
//   vline, newframe        - scanline position / frame pulse from video
//   cmd_addr, cmd_wrdata, cmd_wren, cmd_rddata - CPU port to command RAM
//   reg_scroll_x/y, reg_ctrl - register outputs towards video
//   irq                    - one-cycle pulse per IRQ command
//   busy                   - list walk in progress (FETCH/DECODE/WAIT)
//   pc                     - index of the current command
// ---------------------------------------------------------------------------
module video_rastercmd
  import video_rastercmd_pkg::*;
#(
  parameter  int CMD_DEPTH = 64,
  localparam int AW        = $clog2(CMD_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [8:0]        base_scroll_x,
  input  logic [7:0]        base_scroll_y,
  input  logic [CTRL_W-1:0] base_ctrl,
  input  logic [8:0]        vline,
  input  logic              newframe,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [CMD_W-1:0]  cmd_wrdata,
  input  logic              cmd_wren,
  output logic [CMD_W-1:0]  cmd_rddata,
  output logic [8:0]        reg_scroll_x,
  output logic [7:0]        reg_scroll_y,
  output logic [CTRL_W-1:0] reg_ctrl,
  output logic              irq,
  output logic              busy,
  output logic [AW-1:0]     pc
);

  state_t            r_state;
  logic [AW-1:0]     r_pc;
  logic [8:0]        r_scroll_x;
  logic [7:0]        r_scroll_y;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_irq;
  logic              r_busy;

  logic [SEQ_W-1:0]  w_cmd;
  logic [LINE_W-1:0] w_line;
  logic [OP_W-1:0]   w_op;
  logic [VAL_W-1:0]  w_val;
  logic              w_rd_en;
  logic              w_match;
  logic              w_last;

  rastercmd_ram #(
    .DEPTH (CMD_DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_a_addr  (cmd_addr),
    .i_a_wdata (cmd_wrdata),
    .i_a_wren  (cmd_wren),
    .o_a_rdata (cmd_rddata),
    .i_b_addr  (r_pc),
    .i_b_rden  (w_rd_en),
    .o_b_cmd   (w_cmd)
  );

  assign w_rd_en = (r_state == ST_FETCH);
  assign {w_line, w_op, w_val} = w_cmd;

  // Unsigned compare; lines above 262 can never match, stalling the walk.
  assign w_match = (vline >= w_line);
  // Stop after END or after the last RAM slot; the pc never wraps.
  assign w_last  = (w_op == OP_END) || (r_pc == AW'(CMD_DEPTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_scroll_x <= '0;
      r_scroll_y <= '0;
      r_ctrl     <= '0;
      r_irq      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (newframe) begin
        // Frame start overrides whatever the walk was doing.
        r_scroll_x <= base_scroll_x;
        r_scroll_y <= base_scroll_y;
        r_ctrl     <= base_ctrl;
        r_pc       <= '0;
        r_state    <= enable ? ST_FETCH : ST_IDLE;
        r_busy     <= enable;
      end else begin
        case (r_state)
          ST_IDLE: begin
          end
          ST_FETCH: begin
            r_state <= ST_DECODE;
          end
          ST_DECODE, ST_WAIT: begin
            if (w_match) begin
              case (w_op)
                OP_SETX:    r_scroll_x <= w_val;
                OP_SETY:    r_scroll_y <= w_val[7:0];
                OP_SETCTRL: r_ctrl     <= ctrl_from_value(w_val[CTRL_W-1:0]);
                OP_IRQ:     r_irq      <= 1'b1;
                OP_END, OP_NOP: begin
                end
                default: begin
                end
              endcase
              if (w_last) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
              end else begin
                r_pc    <= r_pc + AW'(1);
                r_state <= ST_FETCH;
              end
            end else begin
              r_state <= ST_WAIT;
            end
          end
          ST_DONE: begin
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign reg_scroll_x = r_scroll_x;
  assign reg_scroll_y = r_scroll_y;
  assign reg_ctrl     = r_ctrl;
  assign irq          = r_irq;
  assign busy         = r_busy;
  assign pc           = r_pc;

endmodule

// File: tb/tb_video_rastercmd.sv
module tb_video_rastercmd;
  import video_rastercmd_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, newframe, cmd_wren;
  logic [8:0]  base_scroll_x, vline;
  logic [7:0]  base_scroll_y;
  logic [5:0]  base_ctrl;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wrdata, cmd_rddata;
  logic [8:0]  reg_scroll_x;
  logic [7:0]  reg_scroll_y;
  logic [5:0]  reg_ctrl;
  logic        irq, busy;
  logic [5:0]  pc;

  int checks   = 0;
  int failures = 0;

  video_rastercmd dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .base_scroll_x (base_scroll_x),
    .base_scroll_y (base_scroll_y),
    .base_ctrl     (base_ctrl),
    .vline         (vline),
    .newframe      (newframe),
    .cmd_addr      (cmd_addr),
    .cmd_wrdata    (cmd_wrdata),
    .cmd_wren      (cmd_wren),
    .cmd_rddata    (cmd_rddata),
    .reg_scroll_x  (reg_scroll_x),
    .reg_scroll_y  (reg_scroll_y),
    .reg_ctrl      (reg_ctrl),
    .irq           (irq),
    .busy          (busy),
    .pc            (pc)
  );

  typedef struct {
    logic [8:0] line;
    logic [3:0] op;
    logic [8:0] val;
    logic [8:0] vl;
    logic [8:0] ex;
    logic [7:0] ey;
    logic [5:0] ec;
    logic       eirq;
    logic       ebusy;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [8:0] l, input logic [3:0] op, input logic [8:0] v);
    return {l, op, 10'd0, v};
  endfunction

  task automatic wr(input int a, input logic [31:0] d);
    cmd_addr   = a[5:0];
    cmd_wrdata = d;
    cmd_wren   = 1'b1;
    tick();
    cmd_wren   = 1'b0;
  endtask

  task automatic frame();
    newframe = 1'b1;
    tick();
    newframe = 1'b0;
  endtask

  initial begin
    int n_irq;
    int irq_line;

    //           line     op          val     vline    x        y      ctrl   irq   busy
    vecs[0]  = '{9'd0,   OP_SETX,    9'h1AB, 9'd0,   9'h1AB, 8'h22, 6'h15, 1'b0, 1'b1};
    vecs[1]  = '{9'd0,   OP_SETY,    9'h1CD, 9'd0,   9'h011, 8'hCD, 6'h15, 1'b0, 1'b1};
    vecs[2]  = '{9'd0,   OP_SETCTRL, 9'h1EA, 9'd0,   9'h011, 8'h22, 6'h2A, 1'b0, 1'b1};
    vecs[3]  = '{9'd0,   OP_IRQ,     9'h000, 9'd0,   9'h011, 8'h22, 6'h15, 1'b1, 1'b1};
    vecs[4]  = '{9'd0,   OP_NOP,     9'h1FF, 9'd0,   9'h011, 8'h22, 6'h15, 1'b0, 1'b1};
    vecs[5]  = '{9'd0,   4'd9,       9'h0AA, 9'd0,   9'h011, 8'h22, 6'h15, 1'b0, 1'b1};
    vecs[6]  = '{9'd0,   OP_END,     9'h055, 9'd0,   9'h011, 8'h22, 6'h15, 1'b0, 1'b0};
    vecs[7]  = '{9'd263, OP_SETX,    9'h0AA, 9'd262, 9'h011, 8'h22, 6'h15, 1'b0, 1'b1};
    vecs[8]  = '{9'd262, OP_SETX,    9'h0AA, 9'd262, 9'h0AA, 8'h22, 6'h15, 1'b0, 1'b1};
    vecs[9]  = '{9'd5,   OP_SETX,    9'h0BC, 9'd4,   9'h011, 8'h22, 6'h15, 1'b0, 1'b1};
    vecs[10] = '{9'd5,   OP_SETY,    9'h0BC, 9'd5,   9'h011, 8'hBC, 6'h15, 1'b0, 1'b1};

    reset         = 1'b0;
    enable        = 1'b1;
    newframe      = 1'b0;
    cmd_wren      = 1'b0;
    cmd_addr      = '0;
    cmd_wrdata    = '0;
    base_scroll_x = 9'h123;
    base_scroll_y = 8'h22;
    base_ctrl     = 6'h15;
    vline         = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_x", reg_scroll_x, 0);
    chk("rst_y", reg_scroll_y, 0);
    chk("rst_ctrl", reg_ctrl, 0);
    chk("rst_irq", irq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc", pc, 0);
    reset = 1'b1;
    tick();

    // Single END list: base load, then busy for FETCH and DECODE only
    wr(0, mk(9'd0, OP_END, 9'd0));
    frame();
    chk("end_x", reg_scroll_x, 9'h123);
    chk("end_busy0", busy, 1);
    tick();
    chk("end_busy1", busy, 1);
    tick();
    chk("end_busy2", busy, 0);
    chk("end_pc", pc, 0);

    // Table of single-command frames: [cmd, END]
    base_scroll_x = 9'h011;
    wr(1, mk(9'd0, OP_END, 9'd0));
    for (int i = 0; i < 11; i++) begin
      wr(0, mk(vecs[i].line, vecs[i].op, vecs[i].val));
      vline = vecs[i].vl;
      frame();
      tick();
      tick();
      chk($sformatf("v%0d_x", i), reg_scroll_x, vecs[i].ex);
      chk($sformatf("v%0d_y", i), reg_scroll_y, vecs[i].ey);
      chk($sformatf("v%0d_ctrl", i), reg_ctrl, vecs[i].ec);
      chk($sformatf("v%0d_irq", i), irq, vecs[i].eirq);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].ebusy);
    end

    // Split at line 100: SETX then SETY two cycles later
    wr(0, mk(9'd100, OP_SETX, 9'h040));
    wr(1, mk(9'd100, OP_SETY, 9'h020));
    wr(2, mk(9'd0, OP_END, 9'd0));
    vline = 9'd0;
    frame();
    repeat (5) tick();
    vline = 9'd99;
    repeat (5) tick();
    chk("split_x99", reg_scroll_x, 9'h011);
    chk("split_y99", reg_scroll_y, 8'h22);
    chk("split_busy99", busy, 1);
    chk("split_pc99", pc, 0);
    vline = 9'd100;
    tick();
    chk("split_x100", reg_scroll_x, 9'h040);
    chk("split_y_t1", reg_scroll_y, 8'h22);
    tick();
    chk("split_y_t2", reg_scroll_y, 8'h22);
    tick();
    chk("split_y_t3", reg_scroll_y, 8'h20);
    tick();
    tick();
    chk("split_busy_done", busy, 0);
    chk("split_pc_done", pc, 2);

    // IRQ at line 50, then a stall on an unreachable line
    wr(0, mk(9'd50, OP_IRQ, 9'd0));
    wr(1, mk(9'd300, OP_NOP, 9'd0));
    vline = 9'd45;
    frame();
    n_irq    = 0;
    irq_line = -1;
    for (int v = 45; v <= 55; v++) begin
      vline = v[8:0];
      repeat (4) begin
        tick();
        if (irq === 1'b1) begin
          n_irq++;
          irq_line = int'(vline);
        end
      end
    end
    chk("irq_count", n_irq, 1);
    chk("irq_line", irq_line, 50);
    chk("stall_busy", busy, 1);
    chk("stall_pc", pc, 1);
    repeat (20) tick();
    chk("stall_busy_late", busy, 1);
    frame();
    chk("stall_nf_pc", pc, 0);
    chk("stall_nf_busy", busy, 1);

    // newframe while waiting at pc=3 restarts the list
    wr(0, mk(9'd0, OP_SETX, 9'h0AA));
    wr(1, mk(9'd0, OP_SETY, 9'h0BB));
    wr(2, mk(9'd0, OP_SETCTRL, 9'h03F));
    wr(3, mk(9'd200, OP_NOP, 9'd0));
    wr(4, mk(9'd0, OP_END, 9'd0));
    vline = 9'd10;
    frame();
    repeat (12) tick();
    chk("wait_pc", pc, 3);
    chk("wait_busy", busy, 1);
    chk("wait_x", reg_scroll_x, 9'h0AA);
    chk("wait_y", reg_scroll_y, 8'hBB);
    chk("wait_ctrl", reg_ctrl, 6'h3F);
    base_scroll_x = 9'h077;
    frame();
    chk("restart_x", reg_scroll_x, 9'h077);
    chk("restart_y", reg_scroll_y, 8'h22);
    chk("restart_ctrl", reg_ctrl, 6'h15);
    chk("restart_pc", pc, 0);
    tick();
    tick();
    chk("restart_exec_x", reg_scroll_x, 9'h0AA);

    // Disabled frame: base values only, enable rising mid-frame is ignored
    enable = 1'b0;
    frame();
    chk("dis_x", reg_scroll_x, 9'h077);
    chk("dis_busy", busy, 0);
    chk("dis_pc", pc, 0);
    tick();
    enable = 1'b1;
    repeat (20) tick();
    chk("dis_x_late", reg_scroll_x, 9'h077);
    chk("dis_ctrl_late", reg_ctrl, 6'h15);
    chk("dis_busy_late", busy, 0);

    // CPU write colliding with the sequencer read: sequencer sees old word
    wr(0, mk(9'd0, OP_SETX, 9'h0AA));
    wr(1, mk(9'd0, OP_END, 9'd0));
    vline = 9'd0;
    frame();
    cmd_addr   = 6'd0;
    cmd_wrdata = mk(9'd0, OP_SETX, 9'h0BB);
    cmd_wren   = 1'b1;
    tick();
    cmd_wren   = 1'b0;
    tick();
    chk("coll_old", reg_scroll_x, 9'h0AA);
    frame();
    tick();
    tick();
    chk("coll_new", reg_scroll_x, 9'h0BB);
    cmd_addr = 6'd0;
    tick();
    chk("cpu_rd0", cmd_rddata, mk(9'd0, OP_SETX, 9'h0BB));
    wr(7, 32'hDEADBEEF);
    tick();
    chk("cpu_rd7", cmd_rddata, 32'hDEADBEEF);

    // Full RAM, no END: every slot executes, stop at pc=63
    for (int i = 0; i < 64; i++) begin
      wr(i, mk(9'd0, OP_SETX, 9'(i)));
    end
    base_scroll_x = 9'h1FF;
    vline = 9'd0;
    frame();
    repeat (20) tick();
    chk("full_x_mid", reg_scroll_x, 9'd9);
    chk("full_busy_mid", busy, 1);
    repeat (120) tick();
    chk("full_x_end", reg_scroll_x, 9'd63);
    chk("full_pc_end", pc, 63);
    chk("full_busy_end", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_rastercmd.md
# video_rastercmd

Per-scanline register sequencer sitting directly upstream of the `video` block. It walks a CPU-written command list once per frame and drives `video`'s register inputs (`reg_scroll_x`, `reg_scroll_y` and the six layer/mode control bits), so those inputs change at chosen scanlines (split-screen scrolling, mode changes, raster IRQs). It consumes `video`'s `vline` and `video_newframe` outputs.

## Interface
- `CMD_DEPTH`, default 64: command RAM entries (power of two); the address width is log2 of this value, 6 at default.
- `clk` input 1: video clock, shared with `video`.
- `reset` input 1: asynchronous, active-low reset.
- `enable` input 1: sequencer enable, sampled at frame start.
- `base_scroll_x` input 9: frame-start value for `reg_scroll_x`.
- `base_scroll_y` input 8: frame-start value for `reg_scroll_y`.
- `base_ctrl` input 6: frame-start control bits, ordered {sprites_enable, gfx_tilemode, gfx_enable, text_priority, text_mode80, text_enable}.
- `vline` input 9: current scanline, range 0..262.
- `newframe` input 1: one-cycle frame-start pulse.
- `cmd_addr` input 6: CPU address into command RAM.
- `cmd_wrdata` input 32: CPU write data.
- `cmd_wren` input 1: CPU write strobe.
- `cmd_rddata` output 32: CPU read data, 1-cycle latency.
- `reg_scroll_x` output 9: drives `video.reg_scroll_x`.
- `reg_scroll_y` output 8: drives `video.reg_scroll_y`.
- `reg_ctrl` output 6: drives the `video` control inputs, same bit order as `base_ctrl`.
- `irq` output 1: one-cycle raster-command interrupt.
- `busy` output 1: high while the list is being walked.
- `pc` output 6: index of the current command.

## Operation
Command word layout:
- [31:23] target line L.
- [22:19] opcode.
- [8:0] value V.

Opcodes:
- 0 END: list finished for this frame.
- 1 NOP: waits for its line, then does nothing.
- 2 SETX: `reg_scroll_x` ← V.
- 3 SETY: `reg_scroll_y` ← V[7:0].
- 4 SETCTRL: `reg_ctrl` ← V[5:0].
- 5 IRQ: pulse `irq`.
- 6..15: treated as NOP.

States:
- IDLE → FETCH: on `newframe` with `enable`=1. In the same edge, load outputs from the `base_*` inputs and clear `pc` to 0.
- IDLE, `newframe` with `enable`=0: load outputs from `base_*`, stay in IDLE.
- FETCH: issue a RAM read at `pc`, go to DECODE.
- DECODE: holds the command word.
  - If `vline` ≥ L: execute the command.
    - END, or `pc` = CMD_DEPTH-1 → DONE.
    - Otherwise `pc`+1 → FETCH.
  - Else → WAIT.
- WAIT: compare every cycle. When `vline` ≥ L, execute exactly as in DECODE.
- DONE: outputs hold until the next `newframe`.

Rules:
- `newframe` in any state restarts from IDLE behaviour and abandons the list mid-walk.
- All comparisons are unsigned 9-bit. L > 262 never matches, so the list stalls in WAIT until the next `newframe`.
- Several commands with the same L execute on consecutive command slots, 2 cycles each. The last write to a register wins.
- `enable` changing mid-frame has no effect until the next `newframe`.

## Timing
- Reset (`reset`=0):
  - `reg_scroll_x`=0, `reg_scroll_y`=0, `reg_ctrl`=0, `irq`=0, `busy`=0, `pc`=0.
  - State is IDLE.
  - RAM contents are undefined.
- Execute latency:
  - From `vline` reaching L while in WAIT, the output register updates on the next edge: 1 cycle.
  - From FETCH, the update lands 2 cycles later.
- `irq` is high for exactly one cycle per IRQ command executed.
- `busy` is 1 in FETCH, DECODE and WAIT; 0 in IDLE and DONE.
- Throughput: at most one command per 2 cycles.
- CPU port:
  - Writes land on the edge after `cmd_wren`.
  - Same-address collision with the sequencer read port: the sequencer sees the old data (read-first).

## Structure
- Shared package `video_rastercmd_pkg` holds:
  - Opcode constants (OP_END..OP_IRQ).
  - State encoding.
  - Field bit positions (LINE_MSB/LSB, OP_MSB/LSB).
  - Control-bit index constants.
- Sub-module `rastercmd_ram`: dual-port CMD_DEPTH×32 RAM.
  - Port A: CPU read/write.
  - Port B: sequencer read-only.
  - Both ports clocked on `clk`, 1-cycle read latency.

## Test plan
- Reset, `base_scroll_x`=0x123, `enable`=1, list = [END], `newframe` → `reg_scroll_x`=0x123 on the next edge; `busy` drops 3 cycles later.
- List [L=100 SETX 0x040, L=100 SETY 0x20, END] → both registers unchanged for `vline` ≤ 99; when `vline`=100, X updates after 1 cycle and Y 2 cycles later.
- List [L=50 IRQ, L=300 NOP] → exactly one `irq` pulse at line 50; `busy` stays 1 until `newframe`, then `pc`=0.
- `newframe` while in WAIT at `pc`=3 → outputs reload from `base_*`, `pc`=0, list restarts.
- `enable`=0 at `newframe` → outputs equal `base_*` and never change for the frame; `busy`=0.
- 64 commands with no END, all L=0 → all 64 execute; state reaches DONE with `pc`=63; no wrap to entry 0.
